// File: rtl/fsic_io_serdes_tx.sv
// fsic_io_serdes_tx: transmit-side lane serializer for the FSIC IO link.
// Parallel frames are queued in a small FIFO and shifted out as
// pCLK_RATIO beats across pNUM_LANES serial lanes. The frame boundary is
// aligned to the coreclk phase counter. Idle (all-zero) frames are sent
// whenever nothing is queued.
module fsic_io_serdes_tx #(
  parameter int pCLK_RATIO    = 4,
  parameter int pNUM_LANES    = 12,
  parameter int pTxFIFO_DEPTH = 4
) (
  input  logic                                   ioclk,
  input  logic                                   axis_rst,
  input  logic                                   txen_ctl,
  input  logic [$clog2(pCLK_RATIO)-1:0]          phase_cnt,
  input  logic [pNUM_LANES*pCLK_RATIO-1:0]       tx_word,
  input  logic                                   tx_word_valid,
  output logic                                   tx_word_ready,
  output logic                                   txen,
  output logic [pNUM_LANES-1:0]                  serial_txd,
  output logic [$clog2(pCLK_RATIO)-1:0]          tx_shift_phase,
  output logic [$clog2(pTxFIFO_DEPTH+1)-1:0]     fifo_level,
  output logic [7:0]                             idle_frame_cnt
);

  localparam int PW = $clog2(pCLK_RATIO);
  localparam int LW = $clog2(pTxFIFO_DEPTH + 1);
  localparam int AW = (pTxFIFO_DEPTH > 1) ? $clog2(pTxFIFO_DEPTH) : 1;
  localparam int FW = pNUM_LANES * pCLK_RATIO;

  localparam logic [PW-1:0] LAST_BEAT = PW'(pCLK_RATIO - 1);
  localparam logic [AW-1:0] LAST_PTR  = AW'(pTxFIFO_DEPTH - 1);
  localparam logic [LW-1:0] DEPTH_LVL = LW'(pTxFIFO_DEPTH);

  logic [FW-1:0] fifo_mem [pTxFIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [FW-1:0] frame_q;

  logic set_en;
  logic load;
  logic push;
  logic pop;

  // Enable qualifies only on the last ioclk of a coreclk cycle, so the
  // first frame boundary coincides with a coreclk boundary.
  assign set_en = txen_ctl && (phase_cnt == LAST_BEAT);

  // A frame is (re)loaded on enable and at every last beat thereafter.
  assign load = txen ? (tx_shift_phase == LAST_BEAT) : set_en;

  // Ready and pop both look at the registered level: a push into an empty
  // FIFO is never bypassed to the lanes, and a full FIFO never accepts a
  // push even when a pop happens in the same cycle.
  assign tx_word_ready = txen && (fifo_level < DEPTH_LVL);
  assign push          = tx_word_valid && tx_word_ready;
  assign pop           = load && (fifo_level != '0);

  // Enable, beat counter, frame register and idle statistics.
  always_ff @(posedge ioclk or posedge axis_rst) begin
    if (axis_rst) begin
      txen           <= 1'b0;
      tx_shift_phase <= '0;
      frame_q        <= '0;
      idle_frame_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values of its peers (load reads tx_shift_phase before it wraps).
      if (set_en) txen <= 1'b1;
      tx_shift_phase <= txen ? tx_shift_phase + 1'b1 : '0;
      if (load) begin
        if (pop) begin
          frame_q <= fifo_mem[rd_ptr];
        end else begin
          frame_q <= '0;
          if (idle_frame_cnt != 8'hFF) idle_frame_cnt <= idle_frame_cnt + 8'd1;
        end
      end
    end
  end

  // FIFO pointers and occupancy; reset simply empties the queue.
  always_ff @(posedge ioclk or posedge axis_rst) begin
    if (axis_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
    end
  end

  // FIFO storage array.
  // NOTE: the storage array has no reset; emptying is done by the pointers
  // and level, and leaving the array unreset keeps it a plain RAM.
  always_ff @(posedge ioclk) begin
    if (push) fifo_mem[wr_ptr] <= tx_word;
  end

  // Lane mux: pick the current beat of each lane's slice of the frame.
  always_comb begin
    logic [pCLK_RATIO-1:0] lane_beats;
    // NOTE: defaults first so every path assigns every bit and no latch is inferred.
    serial_txd = '0;
    lane_beats = '0;
    for (int l = 0; l < pNUM_LANES; l++) begin
      lane_beats    = frame_q[l*pCLK_RATIO +: pCLK_RATIO];
      serial_txd[l] = lane_beats[tx_shift_phase] & txen;
    end
  end

endmodule

// File: doc/fsic_io_serdes_tx.md
Name: fsic_io_serdes_tx

Overview:
- Transmit-side lane serializer for the FSIC inter-chip IO link; the counterpart to the per-lane rx deserializer.
- Accepts parallel frames of pNUM_LANES*pCLK_RATIO bits on a valid/ready handshake and buffers them in a small FIFO.
- Shifts each frame out as pCLK_RATIO consecutive ioclk beats on pNUM_LANES serial lanes, phase-aligned to the coreclk phase counter.
- Sends all-zero idle frames when no data is queued.

Parameters:
- pCLK_RATIO, 4, ioclk cycles per coreclk cycle, which is also beats per frame; power of 2.
- pNUM_LANES, 12, number of serial output lanes.
- pTxFIFO_DEPTH, 4, frame FIFO depth in entries; >=2.

Ports:
- ioclk  in  1  sole clock; all state updates on posedge.
- axis_rst  in  1  asynchronous, active-high reset.
- txen_ctl  in  1  transmit-enable request, level.
- phase_cnt  in  $clog2(pCLK_RATIO)  coreclk phase within ioclk; value pCLK_RATIO-1 marks the last ioclk of a coreclk cycle.
- tx_word  in  pNUM_LANES*pCLK_RATIO  frame data; lane l, beat j = tx_word[l*pCLK_RATIO+j].
- tx_word_valid  in  1  frame valid.
- tx_word_ready  out  1  FIFO can accept a frame.
- txen  out  1  sticky transmit enable; gates the forwarded clock externally.
- serial_txd  out  pNUM_LANES  serial lane data.
- tx_shift_phase  out  $clog2(pCLK_RATIO)  current beat index.
- fifo_level  out  $clog2(pTxFIFO_DEPTH+1)  queued frames.
- idle_frame_cnt  out  8  saturating count of idle frames sent.

Behaviour:
- Reset: all outputs and all state are 0, including txen, serial_txd, tx_word_ready, tx_shift_phase, fifo_level, idle_frame_cnt and frame_q. Reset takes effect asynchronously, including in the middle of a frame, and the FIFO contents are discarded.
- txen:
  - Set at the posedge where txen_ctl==1 and phase_cnt==pCLK_RATIO-1.
  - Sticky until reset; deasserting txen_ctl has no effect.
- tx_shift_phase:
  - Holds 0 while txen==0.
  - While txen==1, increments by 1 each cycle, wrapping pCLK_RATIO-1 -> 0.
  - The first cycle with txen==1 therefore has tx_shift_phase==0.
- Load event L:
  - Occurs at a posedge where (txen==0 and the set condition holds) or (txen==1 and tx_shift_phase==pCLK_RATIO-1).
  - At L, if FIFO not empty: frame_q <= FIFO head, pop.
  - At L, if FIFO empty: frame_q <= 0, idle_frame_cnt += 1, saturating at 255.
- serial_txd[l] = frame_q[l*pCLK_RATIO + tx_shift_phase] & txen. This is combinational from registers, so beat 0 of a loaded frame appears in the cycle after L.
- Handshake:
  - tx_word_ready = txen && (fifo_level < pTxFIFO_DEPTH), computed from the registered level.
  - Push occurs when tx_word_valid && tx_word_ready. Frames are not accepted before txen.
  - A push is held off when the FIFO is full, even if a pop happens in the same cycle; there is no full bypass.
- Simultaneous push and pop: fifo_level is unchanged and order is preserved.
- Push into an empty FIFO at L: no bypass. The pop sees the FIFO empty, so an idle frame is sent, and the pushed word goes out in the next frame.
- Latency: minimum from push to beat 0 on the lanes is 2 cycles. This applies when the push lands in the cycle before L.
- FIFO: circular buffer with wrapping read/write pointers; fifo_level ranges 0..pTxFIFO_DEPTH.

Test Plan:
- Reset held, txen_ctl=0, valid=1 -> txen=0, tx_word_ready=0, serial_txd=12'h000, fifo_level=0, idle_frame_cnt=0.
- Release reset; raise txen_ctl while phase_cnt=1 -> txen rises at the edge sampling phase_cnt=3; tx_shift_phase then reads 0,1,2,3,0; idle_frame_cnt=1 after the first L.
- After enable, push tx_word=48'h8421_8421_8421 -> in its frame serial_txd=12'h111,12'h222,12'h444,12'h888 on beats 0..3; fifo_level returns to 0.
- Push 5 frames back-to-back starting right after an L -> tx_word_ready drops once fifo_level=4; frames emerge in push order; fifo_level steps down by 1 every 4 cycles after the pops.
- Hold tx_word_valid=0 for 300 frames after enable -> serial_txd=0 throughout; idle_frame_cnt increments once per 4 cycles and saturates at 255.
- Mid-frame (tx_shift_phase=2, fifo_level=3) pulse axis_rst -> same timestep serial_txd=0, txen=0, fifo_level=0; after release no data is sent until txen_ctl is re-qualified at phase_cnt=3.
